delay_line: RTL and testbench

DELAY_LINE -- requirements
Module: delay_line

---
 rtl/delay_line_pkg.sv | 15 +
 rtl/delay_stage.sv | 24 ++
 rtl/delay_line.sv | 68 ++++++
 tb/tb_delay_line.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the delay_line block: default and maximum
// INTERVAL/WIDTH values, plus the width function for the priming counter.
package delay_line_pkg;

  localparam int DEF_INTERVAL = 1;
  localparam int DEF_WIDTH    = 1;
  localparam int MAX_INTERVAL = 1024;
  localparam int MAX_WIDTH    = 64;

  // Bits needed to hold a count of 0..interval inclusive.
  function automatic int cnt_width(input int interval);
    return $clog2(interval + 1);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One WIDTH-bit register stage of the delay line, synchronously cleared.
// Powers up at zero so an unreset line still shifts out defined values.
module delay_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q = '0;

  // Load the previous stage every edge; reset discards the held sample.
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/delay_line.sv
// Fixed-length delay line: INTERVAL register stages of WIDTH bits, shifted
// every edge, with a 'primed' flag once the line is full of live samples.
// Optional feature: define DELAY_LINE_TAPS_EN to expose every stage on 'taps'
// (slice k = stage k).
module delay_line
  import delay_line_pkg::*;
#(
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in,
  output logic [WIDTH-1:0]          out,
  output logic                      primed
`ifdef DELAY_LINE_TAPS_EN
  ,
  output logic [INTERVAL*WIDTH-1:0] taps
`endif
);

  localparam int            CW      = cnt_width(INTERVAL);
  localparam logic [CW-1:0] CNT_MAX = CW'(INTERVAL);

  if (INTERVAL < 1 || INTERVAL > MAX_INTERVAL) begin : g_bad_interval
    $error("delay_line: INTERVAL=%0d outside 1..%0d", INTERVAL, MAX_INTERVAL);
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("delay_line: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  logic [WIDTH-1:0] w_stage [INTERVAL];

  // Stage 0 takes the input; every later stage takes its predecessor.
  for (genvar k = 0; k < INTERVAL; k++) begin : g_stage
    logic [WIDTH-1:0] w_d;
    if (k == 0) begin : g_head
      assign w_d = in;
    end else begin : g_link
      assign w_d = w_stage[k-1];
    end
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .i_d (w_d),
      .o_q (w_stage[k])
    );
  end

  assign out = w_stage[INTERVAL-1];

  logic [CW-1:0] r_cnt = '0;

  // Count edges since reset, holding at INTERVAL so primed stays asserted.
  always_ff @(posedge clk) begin
    if (rst)                 r_cnt <= '0;
    else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
  end

  assign primed = (r_cnt == CNT_MAX);

`ifdef DELAY_LINE_TAPS_EN
  for (genvar t = 0; t < INTERVAL; t++) begin : g_tap
    assign taps[t*WIDTH +: WIDTH] = w_stage[t];
  end
`endif

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: several parameterisations share one
// stimulus stream; a history-queue scoreboard predicts every output each edge,
// a vector table covers INTERVAL=4/WIDTH=8, and short sequences cover the
// single-flop, long-line, mid-stream reset and (optional) taps cases.
module tb_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;

  logic       o1,  p1;
  logic       o36, p36;
  logic [7:0] o4;
  logic       p4;
  logic [7:0] o8;
  logic       p8;
  logic [3:0] o3;
  logic       p3;
`ifdef DELAY_LINE_TAPS_EN
  logic [11:0] taps3;
`endif

  delay_line #(.INTERVAL(1),  .WIDTH(1)) u1  (.clk(clk), .rst(rst), .in(din[0]),   .out(o1),  .primed(p1));
  delay_line #(.INTERVAL(36), .WIDTH(1)) u36 (.clk(clk), .rst(rst), .in(din[0]),   .out(o36), .primed(p36));
  delay_line #(.INTERVAL(4),  .WIDTH(8)) u4  (.clk(clk), .rst(rst), .in(din),      .out(o4),  .primed(p4));
  delay_line #(.INTERVAL(8),  .WIDTH(8)) u8  (.clk(clk), .rst(rst), .in(din),      .out(o8),  .primed(p8));
  delay_line #(.INTERVAL(3),  .WIDTH(4)) u3  (.clk(clk), .rst(rst), .in(din[3:0]), .out(o3),  .primed(p3)
`ifdef DELAY_LINE_TAPS_EN
    , .taps(taps3)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Samples accepted since the last reset (newest at the back).
  logic [7:0] hist[$];
  int         nsince = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mexp(input int n);
    if (nsince >= n) return hist[hist.size() - n];
    return 8'h00;
  endfunction

  // Advance one edge, update the scoreboard, then check every instance.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      hist.delete();
      nsince = 0;
    end else begin
      hist.push_back(din);
      nsince++;
      if (hist.size() > 40) void'(hist.pop_front());
    end
    #1;
    chk("sb_out_i1",     64'(o1),  64'(mexp(1)  & 8'h01));
    chk("sb_out_i36",    64'(o36), 64'(mexp(36) & 8'h01));
    chk("sb_out_i4",     64'(o4),  64'(mexp(4)));
    chk("sb_out_i8",     64'(o8),  64'(mexp(8)));
    chk("sb_out_i3",     64'(o3),  64'(mexp(3)  & 8'h0F));
    chk("sb_primed_i1",  64'(p1),  64'(nsince >= 1));
    chk("sb_primed_i36", 64'(p36), 64'(nsince >= 36));
    chk("sb_primed_i4",  64'(p4),  64'(nsince >= 4));
    chk("sb_primed_i8",  64'(p8),  64'(nsince >= 8));
    chk("sb_primed_i3",  64'(p3),  64'(nsince >= 3));
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_primed;
  } vec_t;

  vec_t       vec [20];
  logic [7:0] pat;

  initial begin
    // Vector table for INTERVAL=4, WIDTH=8: 0x01..0x10 back-to-back, then idle.
    for (int i = 0; i < 20; i++) begin
      vec[i].din        = (i < 16) ? 8'(i + 1) : 8'h00;
      vec[i].exp_out    = (i >= 3 && i <= 18) ? 8'(i - 2) : 8'h00;
      vec[i].exp_primed = (i >= 3);
    end

    // Power-up state, before any reset.
    #1;
    chk("pwrup_out_i4",    64'(o4),  64'h0);
    chk("pwrup_out_i8",    64'(o8),  64'h0);
    chk("pwrup_primed_i1", 64'(p1),  64'h0);
    chk("pwrup_primed_i4", 64'(p4),  64'h0);

    // Held reset ignores the input.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'($urandom_range(1, 255));
      tick();
      chk("rst_hold_out_i8",    64'(o8), 64'h0);
      chk("rst_hold_primed_i1", 64'(p1), 64'h0);
    end

    // Single-flop case: one-cycle pulse comes out one edge later for one cycle.
    rst = 1'b0;
    din = 8'h01;
    tick();
    chk("i1_pulse_out",    64'(o1), 64'h1);
    chk("i1_pulse_primed", 64'(p1), 64'h1);
    din = 8'h00;
    tick();
    chk("i1_pulse_end", 64'(o1), 64'h0);

    // Table-driven stream through INTERVAL=4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din = vec[i].din;
      tick();
      chk($sformatf("i4_vec%0d_out", i),    64'(o4), 64'(vec[i].exp_out));
      chk($sformatf("i4_vec%0d_primed", i), 64'(p4), 64'(vec[i].exp_primed));
    end

    // Long line: 0xA5 LSB-first emerges 36 edges later; primed on edge 36.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pat = 8'hA5;
    for (int i = 0; i < 45; i++) begin
      din = (i < 8) ? {7'b0, pat[i]} : 8'h00;
      tick();
      chk($sformatf("i36_bit%0d", i), 64'(o36),
          (i >= 35 && i <= 42) ? 64'(pat[i-35]) : 64'h0);
      chk($sformatf("i36_primed%0d", i), 64'(p36), 64'(i >= 35));
    end

    // Mid-stream reset on INTERVAL=8: in-flight 0xFF samples must vanish.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    chk("i8_midrst_out",    64'(o8), 64'h0);
    chk("i8_midrst_primed", 64'(p8), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      din = (i == 0) ? 8'h3C : 8'h00;
      tick();
      chk($sformatf("i8_after_rst%0d", i), 64'(o8), (i == 7) ? 64'h3C : 64'h0);
      chk($sformatf("i8_primed%0d", i),    64'(p8), 64'(i >= 7));
    end

    // Random free-running traffic checked by the scoreboard alone.
    for (int i = 0; i < 60; i++) begin
      din = 8'($urandom);
      tick();
    end

`ifdef DELAY_LINE_TAPS_EN
    // Taps show stage2..stage0 = oldest..newest.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = 8'h01; tick();
    din = 8'h02; tick();
    din = 8'h03; tick();
    chk("i3_taps", 64'(taps3), 64'h123);
    rst = 1'b1;
    tick();
    chk("i3_taps_rst", 64'(taps3), 64'h000);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
